sc_fifo_param: RTL

- Parametrised native-RTL single-clock FIFO replacing the fixed 32-bit vendor-IP FIFO wrapper.
- Adds configurable width/depth, standard or first-word-fall-through (FWFT) read mode, almost/programmable flags, occupancy count, overflow/underflow pulses, and a reset-busy sequencer.
- Sits between stream producers and consumers in the same clock domain. Drop-in superset of the existing FIFO port list.

---
 rtl/sc_fifo_pkg.sv | 19 +
 rtl/sc_fifo_ram.sv | 33 +++
 rtl/sc_fifo_param.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/sc_fifo_pkg.sv
// Shared types and elaboration-time helpers for the parametrised single-clock FIFO.
package sc_fifo_pkg;

  typedef enum logic {StBusy, StRun} busy_state_e;

  typedef enum logic {StIdle, StValid} stage_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) result++;
    return result;
  endfunction

  function automatic int unsigned fifo_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/sc_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module sc_fifo_ram
  import sc_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [fifo_depth(ADDR_W)];

  // The array carries no reset so it maps onto block or distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sc_fifo_param.sv
// Single-clock FIFO with standard or first-word-fall-through read, registered flags,
// occupancy count, overflow/underflow pulses and a post-reset busy sequencer.
module sc_fifo_param
  import sc_fifo_pkg::*;
#(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned ADDR_W        = 9,
  parameter int unsigned FWFT          = 0,
  parameter int unsigned PROG_FULL_TH  = (2 ** ADDR_W) - 16,
  parameter int unsigned PROG_EMPTY_TH = 16,
  parameter int unsigned RST_BUSY_CYC  = 4
) (
  input  logic              clk,
  input  logic              srst,
  input  logic [DATA_W-1:0] din,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              prog_full,
  output logic              prog_empty,
  output logic [ADDR_W:0]   data_count,
  output logic              overflow,
  output logic              underflow,
  output logic              wr_rst_busy,
  output logic              rd_rst_busy
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_W);
  localparam int unsigned BusyW = clog2(RST_BUSY_CYC + 1);

  typedef logic [ADDR_W:0]   cnt_t;
  typedef logic [ADDR_W-1:0] ptr_t;

  busy_state_e      busy_q, busy_d;
  logic [BusyW-1:0] busy_cnt_q, busy_cnt_d;
  stage_state_e     stage_q, stage_d;
  ptr_t             wr_ptr_q, rd_ptr_q;
  cnt_t             count_q, count_d;

  logic full_q, empty_q, almost_full_q, almost_empty_q, prog_full_q, prog_empty_q;
  logic overflow_q, underflow_q;
  logic full_d, empty_d, almost_full_d, almost_empty_d, prog_full_d, prog_empty_d;
  logic overflow_d, underflow_d;

  logic busy_now, busy_next, wr_acc, rd_acc, ram_nonempty, ram_rd;

  always_comb begin
    busy_d     = busy_q;
    busy_cnt_d = busy_cnt_q;
    if (busy_q == StBusy) begin
      if (busy_cnt_q == BusyW'(RST_BUSY_CYC - 1)) begin
        busy_d = StRun;
      end else begin
        busy_cnt_d = busy_cnt_q + 1'b1;
      end
    end
  end

  assign busy_now  = (busy_q == StBusy);
  assign busy_next = (busy_d == StBusy);

  // full/empty already include busy, so nothing is accepted during the busy period.
  assign wr_acc = wr_en && !full_q;
  assign rd_acc = rd_en && !empty_q;

  // In FWFT mode the output stage holds one of the counted words.
  assign ram_nonempty = (FWFT != 0) ? (count_q > cnt_t'(stage_q == StValid))
                                    : (count_q != '0);
  assign ram_rd       = (FWFT != 0) ? (ram_nonempty && (stage_q == StIdle || rd_acc))
                                    : rd_acc;

  always_comb begin
    stage_d = stage_q;
    if (FWFT != 0) begin
      if (ram_rd)      stage_d = StValid;
      else if (rd_acc) stage_d = StIdle;
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    full_d         = busy_next || (count_d == cnt_t'(DEPTH));
    empty_d        = busy_next || ((FWFT != 0) ? (stage_d == StIdle) : (count_d == '0));
    almost_full_d  = count_d >= cnt_t'(DEPTH - 1);
    almost_empty_d = count_d <= cnt_t'(1);
    prog_full_d    = count_d >= cnt_t'(PROG_FULL_TH);
    prog_empty_d   = count_d <= cnt_t'(PROG_EMPTY_TH);
    overflow_d     = wr_en && full_q && !busy_now;
    underflow_d    = rd_en && empty_q && !busy_now;
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      busy_q         <= StBusy;
      busy_cnt_q     <= '0;
      stage_q        <= StIdle;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      full_q         <= 1'b1;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      prog_full_q    <= 1'b0;
      prog_empty_q   <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      busy_q         <= busy_d;
      busy_cnt_q     <= busy_cnt_d;
      stage_q        <= stage_d;
      wr_ptr_q       <= wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_q       <= ram_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_q        <= count_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      prog_full_q    <= prog_full_d;
      prog_empty_q   <= prog_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  sc_fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (srst),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (din),
    .rd_en   (ram_rd),
    .rd_addr (rd_ptr_q),
    .rd_data (dout)
  );

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign prog_full    = prog_full_q;
  assign prog_empty   = prog_empty_q;
  assign data_count   = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign wr_rst_busy  = busy_now;
  assign rd_rst_busy  = busy_now;

endmodule
